// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared state encoding, register constants and stage-control struct
package hazard_ctrl_pkg;
  typedef logic [1:0] state_t;
  localparam state_t ST_BOOT = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_MISS = 2'd2;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] M_F   = 5'b10000;
  localparam logic [4:0] M_D   = 5'b01000;
  localparam logic [4:0] M_E   = 5'b00100;
  localparam logic [4:0] M_ALL = 5'b11111;
  typedef struct packed {
    logic [4:0] bubble;
    logic [4:0] flush;
  } stage_ctl_t;
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);
  logic [CNT_W-1:0] count_q;
  // count up on each event until every bit is set
  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= '0;
    else if (inc_i && !(&count_q)) count_q <= count_q + 1'b1;
  assign count_o = count_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: boot flush, load-use stall, redirect flush and dcache-miss stall sequencing
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES  = 4,
  parameter int MISS_TIMEOUT = 1024,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       reg1_srcD,
  input  logic [4:0]       reg2_srcD,
  input  logic [4:0]       reg_dstE,
  input  logic             load_E,
  input  logic             br_E,
  input  logic             jalr_E,
  input  logic             jal_D,
  input  logic             miss,
  output logic             bubbleF,
  output logic             bubbleD,
  output logic             bubbleE,
  output logic             bubbleM,
  output logic             bubbleW,
  output logic             flushF,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic             err_timeout,
  output logic [CNT_W-1:0] cnt_lu,
  output logic [CNT_W-1:0] cnt_redir,
  output logic [CNT_W-1:0] cnt_miss
);
  localparam int BW = $clog2(BOOT_CYCLES) + 1;
  localparam int MW = $clog2(MISS_TIMEOUT);
  state_t state_q, state_d;
  logic [BW-1:0] boot_q, boot_d;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic err_q, err_d;
  logic boot, stall, redir, lu, inc_lu, inc_redir;
  stage_ctl_t ctl;
  // priority decode: boot flush > miss stall > redirect > load-use > jal
  always_comb begin
    boot       = state_q == ST_BOOT;
    stall      = !boot && miss;
    redir      = br_E || jalr_E;
    lu         = load_E && reg_dstE != REG_ZERO && (reg_dstE == reg1_srcD || reg_dstE == reg2_srcD);
    ctl.flush  = boot ? M_ALL : stall ? '0 : redir ? (M_D | M_E) : lu ? M_E : jal_D ? M_D : '0;
    ctl.bubble = stall ? M_ALL : (!boot && !redir && lu) ? (M_F | M_D) : '0;
    inc_lu     = !boot && !stall && !redir && lu;
    inc_redir  = !boot && !stall && (redir || (!lu && jal_D));
    state_d    = boot ? (boot_q == BW'(BOOT_CYCLES - 1) ? ST_RUN : ST_BOOT) : stall ? ST_MISS : ST_RUN;
    boot_d     = boot ? boot_q + 1'b1 : '0;
    mcnt_d     = !stall ? '0 : mcnt_q == MW'(MISS_TIMEOUT - 1) ? mcnt_q : mcnt_q + 1'b1;
    err_d      = err_q || (state_q == ST_MISS && miss && mcnt_q == MW'(MISS_TIMEOUT - 1));
  end
  // FSM, boot/miss counters and sticky timeout flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_BOOT;
      boot_q  <= '0;
      mcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      mcnt_q  <= mcnt_d;
      err_q   <= err_d;
    end
  assign {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW} = ctl.bubble;
  assign {flushF, flushD, flushE, flushM, flushW}      = ctl.flush;
  assign err_timeout = err_q;
  sat_counter #(.CNT_W(CNT_W)) u_cnt_lu    (.clk(clk), .rst(rst), .inc_i(inc_lu),    .count_o(cnt_lu));
  sat_counter #(.CNT_W(CNT_W)) u_cnt_redir (.clk(clk), .rst(rst), .inc_i(inc_redir), .count_o(cnt_redir));
  sat_counter #(.CNT_W(CNT_W)) u_cnt_miss  (.clk(clk), .rst(rst), .inc_i(stall),     .count_o(cnt_miss));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table plus boot, miss, timeout and reset sequences
module tb_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] reg1_srcD, reg2_srcD, reg_dstE;
  logic load_E, br_E, jalr_E, jal_D, miss;
  logic bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
  logic flushF, flushD, flushE, flushM, flushW;
  logic err_timeout;
  logic [3:0] cnt_lu, cnt_redir, cnt_miss;
  logic [4:0] bub, fl;
  int checks = 0, errors = 0;
  int exp_lu = 0, exp_redir = 0;

  always #5 clk = ~clk;
  assign bub = {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW};
  assign fl  = {flushF, flushD, flushE, flushM, flushW};

  hazard_ctrl #(.BOOT_CYCLES(4), .MISS_TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .reg1_srcD(reg1_srcD), .reg2_srcD(reg2_srcD), .reg_dstE(reg_dstE),
    .load_E(load_E), .br_E(br_E), .jalr_E(jalr_E), .jal_D(jal_D), .miss(miss),
    .bubbleF(bubbleF), .bubbleD(bubbleD), .bubbleE(bubbleE), .bubbleM(bubbleM), .bubbleW(bubbleW),
    .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .err_timeout(err_timeout), .cnt_lu(cnt_lu), .cnt_redir(cnt_redir), .cnt_miss(cnt_miss));

  typedef struct {
    logic [4:0] r1, r2, d;
    logic ld, br, jr, jl;
    logic [4:0] e_bub, e_fl;
    int d_lu, d_redir;
  } vec_t;
  vec_t v[10];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] r1, r2, d, input logic ld, br, jr, jl, ms);
    reg1_srcD = r1; reg2_srcD = r2; reg_dstE = d;
    load_E = ld; br_E = br; jalr_E = jr; jal_D = jl; miss = ms;
  endtask

  task automatic boot_seq();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("boot_flush", 32'(fl), 32'h1f);
      chk("boot_bubble", 32'(bub), 0);
      if (i == 2) drive(0, 0, 0, 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    chk("post_boot_flush", 32'(fl), 0);
    chk("post_boot_bubble", 32'(bub), 0);
  endtask

  initial begin
    v[0] = '{0, 0, 0,  0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0};
    v[1] = '{3, 5, 5,  1, 0, 0, 0, 5'b11000, 5'b00100, 1, 0};
    v[2] = '{0, 0, 0,  1, 0, 0, 0, 5'b00000, 5'b00000, 0, 0};
    v[3] = '{5, 1, 5,  1, 1, 0, 0, 5'b00000, 5'b01100, 0, 1};
    v[4] = '{2, 3, 4,  0, 0, 1, 0, 5'b00000, 5'b01100, 0, 1};
    v[5] = '{2, 3, 4,  0, 0, 0, 1, 5'b00000, 5'b01000, 0, 1};
    v[6] = '{7, 1, 7,  1, 0, 0, 1, 5'b11000, 5'b00100, 1, 0};
    v[7] = '{5, 5, 5,  0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0};
    v[8] = '{31, 31, 31, 1, 0, 0, 0, 5'b11000, 5'b00100, 1, 0};
    v[9] = '{1, 2, 3,  0, 1, 0, 1, 5'b00000, 5'b01100, 0, 1};
    drive(5, 5, 5, 1, 1, 0, 1, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flush", 32'(fl), 32'h1f);
    chk("rst_bubble", 32'(bub), 0);
    chk("rst_cnt_lu", 32'(cnt_lu), 0);
    chk("rst_err", 32'(err_timeout), 0);
    rst = 1'b0;
    boot_seq();
    chk("boot_cnt_lu", 32'(cnt_lu), 0);
    chk("boot_cnt_redir", 32'(cnt_redir), 0);
    chk("boot_cnt_miss", 32'(cnt_miss), 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      drive(v[i].r1, v[i].r2, v[i].d, v[i].ld, v[i].br, v[i].jr, v[i].jl, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_bubble", i), 32'(bub), 32'(v[i].e_bub));
      chk($sformatf("vec%0d_flush", i), 32'(fl), 32'(v[i].e_fl));
      exp_lu += v[i].d_lu;
      exp_redir += v[i].d_redir;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_cnt_lu", i), 32'(cnt_lu), 32'(exp_lu));
      chk($sformatf("vec%0d_cnt_redir", i), 32'(cnt_redir), 32'(exp_redir));
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0, 1);
      @(negedge clk);
      chk("miss_bubble", 32'(bub), 32'h1f);
      chk("miss_flush", 32'(fl), 0);
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("miss_exit_flush", 32'(fl), 32'b01100);
    chk("miss_exit_bubble", 32'(bub), 0);
    @(posedge clk);
    #1;
    chk("miss_cnt3", 32'(cnt_miss), 3);
    chk("miss_exit_redir", 32'(cnt_redir), 32'(exp_redir + 1));
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      chk($sformatf("timeout_c%0d", i), 32'(err_timeout), 32'(i >= 8));
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("timeout_sticky", 32'(err_timeout), 1);
    chk("timeout_exit_bubble", 32'(bub), 0);
    chk("cnt_miss_saturated", 32'(cnt_miss), 15);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    @(negedge clk);
    chk("mw_bubble", 32'(bub), 32'h1f);
    rst = 1'b1;
    #1;
    chk("midmiss_rst_flush", 32'(fl), 32'h1f);
    chk("midmiss_rst_bubble", 32'(bub), 0);
    chk("midmiss_rst_cnt_miss", 32'(cnt_miss), 0);
    chk("midmiss_rst_cnt_lu", 32'(cnt_lu), 0);
    chk("midmiss_rst_err", 32'(err_timeout), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    boot_seq();
    chk("reboot_err", 32'(err_timeout), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
